timer_ctrl: RTL and testbench

Sequencing controller for the countdown timer datapath. Owns the user-editable BCD preset (hour/min/sec), issues the one-cycle load that copies the preset into the datapath's binary down-counters, and gates the 1 Hz tick into the datapath's count enable. Detects expiry from the datapath's count values and drives a timed alarm. It sits between the debounced button pulses / 1 Hz strobe and the timer datapath.

---
 rtl/timer_ctrl_pkg.sv | 10 +
 rtl/timer_ctrl_bcd_inc.sv | 10 +
 rtl/timer_ctrl.sv | 128 ++++++++++++
 tb/tb_timer_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg: shared state, edit-field encodings and BCD limits for the timer controller.
package timer_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SET, S_LOAD, S_RUN, S_PAUSE, S_DONE} state_t;
  localparam logic [1:0] EF_NONE = 2'd0;
  localparam logic [1:0] EF_HOUR = 2'd1;
  localparam logic [1:0] EF_MIN  = 2'd2;
  localparam logic [1:0] EF_SEC  = 2'd3;
  localparam logic [7:0] BCD_MS_MAX   = 8'h59;
  localparam logic [7:0] BCD_HOUR_MAX = 8'h23;
endpackage

// File: rtl/timer_ctrl_bcd_inc.sv
// timer_ctrl_bcd_inc: 2-digit BCD increment that wraps to 00 after the supplied limit.
module timer_ctrl_bcd_inc (
  input  logic [7:0] i_val,
  input  logic [7:0] i_max,
  output logic [7:0] o_val
);
  always_comb o_val = (i_val == i_max)     ? 8'h00 :
                      (i_val[3:0] == 4'd9) ? {i_val[7:4] + 4'd1, 4'd0} :
                                             {i_val[7:4], i_val[3:0] + 4'd1};
endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: countdown timer sequencer owning the BCD preset, load strobe, tick gating and alarm.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int unsigned  ALARM_SECS = 10,
  parameter logic [7:0]   HOUR_MAX   = BCD_HOUR_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       i_btn_mode,
  input  logic       i_btn_start,
  input  logic       i_btn_up,
  input  logic       i_btn_clear,
  input  logic [4:0] i_cnt_hour,
  input  logic [5:0] i_cnt_min,
  input  logic [5:0] i_cnt_sec,
  output logic [7:0] o_set_hour,
  output logic [7:0] o_set_min,
  output logic [7:0] o_set_sec,
  output logic       o_load,
  output logic       o_count_en,
  output logic [1:0] o_edit_field,
  output logic       o_running,
  output logic       o_alarm
);
  state_t     r_state, w_next;
  logic [7:0] r_hour, r_min, r_sec, w_inc_in, w_inc_max, w_inc_out;
  logic [1:0] r_edit, w_edit;
  logic [5:0] r_acnt, w_acnt;
  logic       r_load, r_running, r_alarm, w_reload;
  logic       w_clr, w_start, w_mode, w_up, w_zero, w_preset_nz;

  assign w_clr       = i_btn_clear;
  assign w_start     = i_btn_start & ~i_btn_clear;
  assign w_mode      = i_btn_mode & ~i_btn_start & ~i_btn_clear;
  assign w_up        = i_btn_up & ~i_btn_mode & ~i_btn_start & ~i_btn_clear;
  assign w_zero      = ~|{i_cnt_hour, i_cnt_min, i_cnt_sec};
  assign w_preset_nz = |{r_hour, r_min, r_sec};
  assign w_inc_in    = (r_edit == EF_HOUR) ? r_hour : (r_edit == EF_MIN) ? r_min : r_sec;
  assign w_inc_max   = (r_edit == EF_HOUR) ? HOUR_MAX : BCD_MS_MAX;

  timer_ctrl_bcd_inc u_bcd_inc (.i_val(w_inc_in), .i_max(w_inc_max), .o_val(w_inc_out));

  // A start in the reload cycle after a clear is ignored so load never spans two cycles
  always_comb begin
    w_next   = r_state;
    w_edit   = r_edit;
    w_acnt   = r_acnt;
    w_reload = 1'b0;
    case (r_state)
      S_IDLE:  if (w_start && w_preset_nz && !r_load) w_next = S_LOAD;
               else if (w_mode) begin
                 w_next = S_SET;
                 w_edit = EF_HOUR;
               end
      S_SET:   if (w_mode) begin
                 w_edit = (r_edit == EF_SEC) ? EF_NONE : r_edit + 2'd1;
                 w_next = (r_edit == EF_SEC) ? S_IDLE : S_SET;
               end
      S_LOAD:  w_next = S_RUN;
      S_RUN:   if (w_clr) begin
                 w_next   = S_IDLE;
                 w_reload = 1'b1;
               end else if (w_zero) w_next = S_DONE;
               else if (w_start) w_next = S_PAUSE;
      S_PAUSE: if (w_clr) begin
                 w_next   = S_IDLE;
                 w_reload = 1'b1;
               end else if (w_start) w_next = S_RUN;
      S_DONE:  if (w_clr) begin
                 w_next   = S_IDLE;
                 w_reload = 1'b1;
               end else if (w_start) w_next = S_IDLE;
               else if (i_tick) begin
                 w_acnt = r_acnt + 6'd1;
                 w_next = (r_acnt == 6'(ALARM_SECS - 1)) ? S_IDLE : S_DONE;
               end
      default: w_next = S_IDLE;
    endcase
    if (w_next != S_DONE) w_acnt = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_edit    <= EF_NONE;
      r_acnt    <= '0;
      r_load    <= 1'b0;
      r_running <= 1'b0;
      r_alarm   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_edit    <= w_edit;
      r_acnt    <= w_acnt;
      r_load    <= (w_next == S_LOAD) | w_reload;
      r_running <= (w_next == S_RUN);
      r_alarm   <= (w_next == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hour <= 8'h00;
      r_min  <= 8'h00;
      r_sec  <= 8'h00;
    end else if (r_state == S_SET) begin
      if (w_clr) begin
        r_hour <= 8'h00;
        r_min  <= 8'h00;
        r_sec  <= 8'h00;
      end else if (w_up) begin
        if (r_edit == EF_HOUR) r_hour <= w_inc_out;
        if (r_edit == EF_MIN)  r_min  <= w_inc_out;
        if (r_edit == EF_SEC)  r_sec  <= w_inc_out;
      end
    end
  end

  assign o_set_hour   = r_hour;
  assign o_set_min    = r_min;
  assign o_set_sec    = r_sec;
  assign o_load       = r_load;
  assign o_count_en   = i_tick & (r_state == S_RUN);
  assign o_edit_field = r_edit;
  assign o_running    = r_running;
  assign o_alarm      = r_alarm;
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: vector table, directed corner sequences and a randomized run against a seconds-level reference model.
module tb_timer_ctrl;
  localparam int ALARM = 10;
  localparam int HOUR_WRAP = 24;
  localparam int M_IDLE = 0, M_SET = 1, M_LOAD = 2, M_RUN = 3, M_PAUSE = 4, M_DONE = 5;

  logic clk = 1'b0, rst = 1'b0;
  logic i_tick = 1'b0, i_btn_mode = 1'b0, i_btn_start = 1'b0, i_btn_up = 1'b0, i_btn_clear = 1'b0;
  logic [4:0] cnt_hour;
  logic [5:0] cnt_min, cnt_sec;
  logic [7:0] o_set_hour, o_set_min, o_set_sec;
  logic       o_load, o_count_en, o_running, o_alarm, last_ce;
  logic [1:0] o_edit_field;
  int checks = 0, errors = 0;
  int dp;
  int m_st, m_h, m_m, m_s, m_fld, m_ticks;
  bit m_load;

  timer_ctrl dut (
    .clk(clk), .rst(rst), .i_tick(i_tick), .i_btn_mode(i_btn_mode), .i_btn_start(i_btn_start),
    .i_btn_up(i_btn_up), .i_btn_clear(i_btn_clear), .i_cnt_hour(cnt_hour), .i_cnt_min(cnt_min),
    .i_cnt_sec(cnt_sec), .o_set_hour(o_set_hour), .o_set_min(o_set_min), .o_set_sec(o_set_sec),
    .o_load(o_load), .o_count_en(o_count_en), .o_edit_field(o_edit_field), .o_running(o_running),
    .o_alarm(o_alarm)
  );

  always #5 clk = ~clk;

  function automatic int b2i(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] i2b(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  // Behavioural datapath: total remaining seconds, loaded from the preset, counted down by count_en
  always @(posedge clk or negedge rst)
    if (!rst) dp <= 0;
    else if (o_load) dp <= b2i(o_set_hour) * 3600 + b2i(o_set_min) * 60 + b2i(o_set_sec);
    else if (o_count_en && dp > 0) dp <= dp - 1;

  assign cnt_hour = 5'(dp / 3600);
  assign cnt_min  = 6'((dp / 60) % 60);
  assign cnt_sec  = 6'(dp % 60);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic c, input logic s, input logic md, input logic u, input logic t);
    @(negedge clk);
    {i_btn_clear, i_btn_start, i_btn_mode, i_btn_up, i_tick} = {c, s, md, u, t};
    #1 last_ce = o_count_en;
    @(posedge clk);
    #1 {i_btn_clear, i_btn_start, i_btn_mode, i_btn_up, i_tick} = '0;
  endtask

  task automatic model_step(input bit c, input bit s, input bit md, input bit u, input bit t);
    int b;
    bit nz, nl;
    b  = c ? 1 : s ? 2 : md ? 3 : u ? 4 : 0;
    nz = (m_h + m_m + m_s) != 0;
    nl = 0;
    case (m_st)
      M_IDLE:  if (b == 2 && nz && !m_load) begin m_st = M_LOAD; nl = 1; end
               else if (b == 3) begin m_st = M_SET; m_fld = 1; end
      M_SET:   if (b == 1) begin m_h = 0; m_m = 0; m_s = 0; end
               else if (b == 3) begin
                 if (m_fld == 3) begin m_fld = 0; m_st = M_IDLE; end else m_fld++;
               end else if (b == 4) begin
                 if (m_fld == 1) m_h = (m_h + 1) % HOUR_WRAP;
                 if (m_fld == 2) m_m = (m_m + 1) % 60;
                 if (m_fld == 3) m_s = (m_s + 1) % 60;
               end
      M_LOAD:  m_st = M_RUN;
      M_RUN:   if (b == 1) begin m_st = M_IDLE; nl = 1; end
               else if (dp == 0) begin m_st = M_DONE; m_ticks = 0; end
               else if (b == 2) m_st = M_PAUSE;
      M_PAUSE: if (b == 1) begin m_st = M_IDLE; nl = 1; end
               else if (b == 2) m_st = M_RUN;
      default: if (b == 1) begin m_st = M_IDLE; nl = 1; end
               else if (b == 2) m_st = M_IDLE;
               else if (t) begin m_ticks++; if (m_ticks == ALARM) m_st = M_IDLE; end
    endcase
    m_load = nl;
  endtask

  typedef struct {
    logic [3:0] btn;
    int         n;
    logic [1:0] edit;
    logic [7:0] h, m, s;
    logic       load, run;
  } vec_t;
  vec_t tbl[15];

  initial begin
    // {clear,start,mode,up}, repeat count, expected state after the last repeat
    tbl[0]  = '{4'b0010, 1,  2'd1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{4'b0001, 3,  2'd1, 8'h03, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{4'b0010, 1,  2'd2, 8'h03, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[3]  = '{4'b0001, 25, 2'd2, 8'h03, 8'h25, 8'h00, 1'b0, 1'b0};
    tbl[4]  = '{4'b0010, 1,  2'd3, 8'h03, 8'h25, 8'h00, 1'b0, 1'b0};
    tbl[5]  = '{4'b0001, 60, 2'd3, 8'h03, 8'h25, 8'h00, 1'b0, 1'b0};
    tbl[6]  = '{4'b0010, 1,  2'd0, 8'h03, 8'h25, 8'h00, 1'b0, 1'b0};
    tbl[7]  = '{4'b1110, 1,  2'd0, 8'h03, 8'h25, 8'h00, 1'b0, 1'b0};
    tbl[8]  = '{4'b0011, 1,  2'd1, 8'h03, 8'h25, 8'h00, 1'b0, 1'b0};
    tbl[9]  = '{4'b1110, 1,  2'd1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[10] = '{4'b0010, 3,  2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[11] = '{4'b0010, 1,  2'd1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[12] = '{4'b0001, 24, 2'd1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[13] = '{4'b0010, 3,  2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[14] = '{4'b0100, 1,  2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};

    i_tick = 1'b1;
    #12 chk("reset", {o_set_hour, o_set_min, o_set_sec, o_load, o_count_en, o_edit_field, o_running, o_alarm}, '0);
    @(negedge clk);
    rst = 1'b1;
    i_tick = 1'b0;

    for (int i = 0; i < 15; i++) begin
      for (int r = 0; r < tbl[i].n; r++) cyc(tbl[i].btn[3], tbl[i].btn[2], tbl[i].btn[1], tbl[i].btn[0], 1'b0);
      chk($sformatf("vec%0d", i), {o_edit_field, o_set_hour, o_set_min, o_set_sec, o_load, o_running},
          {tbl[i].edit, tbl[i].h, tbl[i].m, tbl[i].s, tbl[i].load, tbl[i].run});
    end

    // preset 00:00:02
    repeat (3) cyc(0, 0, 1, 0, 0);
    repeat (2) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0);
    chk("preset2", {o_edit_field, o_set_hour, o_set_min, o_set_sec}, {2'd0, 24'h000002});
    cyc(0, 1, 0, 0, 0);
    chk("load_cycle", {o_load, o_running}, 2'b10);
    cyc(0, 0, 0, 0, 1);
    chk("ce_in_load", last_ce, 1'b0);
    chk("run_entry", {o_load, o_running}, 2'b01);
    cyc(0, 0, 0, 0, 1);
    chk("ce_run_tick", last_ce, 1'b1);
    cyc(0, 1, 0, 0, 1);
    chk("ce_with_pause", last_ce, 1'b1);
    chk("paused", o_running, 1'b0);
    cyc(0, 0, 0, 0, 1);
    chk("ce_paused", last_ce, 1'b0);
    cyc(0, 1, 0, 0, 0);
    chk("resume", {o_running, o_alarm}, 2'b10);
    chk("dp_zero", dp, 0);
    cyc(0, 0, 0, 0, 0);
    chk("done_entry", {o_running, o_alarm}, 2'b01);
    for (int k = 1; k <= ALARM; k++) begin
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1);
      chk($sformatf("alarm_tick%0d", k), o_alarm, k < ALARM);
    end
    chk("alarm_idle", {o_running, o_edit_field, o_load}, '0);

    // clear in the same cycle as expiry
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("zero_in_run", {dp[7:0], o_running}, {8'd0, 1'b1});
    cyc(1, 0, 0, 0, 0);
    chk("clear_beats_zero", {o_load, o_alarm, o_running}, 3'b100);
    cyc(0, 0, 0, 0, 0);
    chk("reload_one_cycle", {o_load, o_alarm, o_running}, 3'b000);

    // async reset mid-DONE
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk("done_before_rst", o_alarm, 1'b1);
    @(negedge clk);
    i_tick = 1'b1;
    #2 rst = 1'b0;
    #1 chk("async_rst", {o_set_hour, o_set_min, o_set_sec, o_load, o_count_en, o_edit_field, o_running, o_alarm}, '0);
    m_st = M_IDLE; m_h = 0; m_m = 0; m_s = 0; m_fld = 0; m_ticks = 0; m_load = 0;
    @(negedge clk);
    i_tick = 1'b0;
    rst = 1'b1;

    for (int n = 0; n < 4000; n++) begin
      logic c, s, md, u, t;
      @(negedge clk);
      c  = ($urandom_range(79) == 0);
      s  = ($urandom_range(24) == 0);
      md = ($urandom_range(11) == 0);
      u  = ($urandom_range(5) == 0);
      t  = ($urandom_range(1) == 0);
      {i_btn_clear, i_btn_start, i_btn_mode, i_btn_up, i_tick} = {c, s, md, u, t};
      #1 chk("rnd_ce", o_count_en, t && (m_st == M_RUN));
      model_step(c, s, md, u, t);
      @(posedge clk);
      #1 chk("rnd_out", {o_set_hour, o_set_min, o_set_sec, o_load, o_edit_field, o_running, o_alarm},
                {i2b(m_h), i2b(m_m), i2b(m_s), m_load, 2'(m_fld), m_st == M_RUN, m_st == M_DONE});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
